// File: rtl/mmio_port_responder.sv
// mmio_port_responder: data-bus slave holding an output port, a synchronized input port
// with rise detection, and a one-shot down-counting timer with sticky status flags.
`default_nettype none

module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        Irq
);

  localparam logic [4:0] OFF_PORT_OUT    = 5'h00;
  localparam logic [4:0] OFF_PORT_IN     = 5'h04;
  localparam logic [4:0] OFF_STATUS      = 5'h08;
  localparam logic [4:0] OFF_TIMER_LOAD  = 5'h0C;
  localparam logic [4:0] OFF_TIMER_COUNT = 5'h10;

  logic [31:0] port_out_q, port_out_d;
  logic [7:0]  sync1_q, sync2_q, prev_q;
  logic        rise_q, rise_d;
  logic        tdone_q, tdone_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        running_q, running_d;

  logic [4:0]  offset;
  logic        base_match;
  logic        offset_valid;
  logic        wr_en;
  logic        wr_port_out;
  logic        wr_status;
  logic        wr_load;
  logic        rise_evt;
  logic        tdone_evt;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign offset     = Address[4:0];
  assign base_match = (Address[31:5] == BASE_ADDRESS[31:5]);

  always_comb begin
    offset_valid = 1'b0;
    case (offset)
      OFF_PORT_OUT, OFF_PORT_IN, OFF_STATUS,
      OFF_TIMER_LOAD, OFF_TIMER_COUNT: offset_valid = 1'b1;
      default:                         offset_valid = 1'b0;
    endcase
  end

  assign Hit         = base_match & offset_valid;
  assign wr_en       = Hit & MemWrite;
  assign wr_port_out = wr_en & (offset == OFF_PORT_OUT);
  assign wr_status   = wr_en & (offset == OFF_STATUS);
  assign wr_load     = wr_en & (offset == OFF_TIMER_LOAD);

  // ---------------------------------------------------------------------------
  // Read mux: purely combinational so loads complete in the same cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    ReadData = 32'd0;
    if (Hit && MemRead) begin
      case (offset)
        OFF_PORT_OUT:    ReadData = port_out_q;
        OFF_PORT_IN:     ReadData = {24'd0, sync2_q};
        OFF_STATUS:      ReadData = {30'd0, tdone_q, rise_q};
        OFF_TIMER_LOAD:  ReadData = load_q;
        OFF_TIMER_COUNT: ReadData = count_q;
        default:         ReadData = 32'd0;
      endcase
    end
  end

  assign rise_evt = |(sync2_q & ~prev_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    port_out_d = port_out_q;
    load_d     = load_q;
    count_d    = count_q;
    running_d  = running_q;
    tdone_evt  = 1'b0;

    if (wr_port_out) begin
      port_out_d = WriteData;
    end

    // A load always overrides the decrement, including on the expiry edge.
    if (wr_load) begin
      load_d    = WriteData;
      count_d   = WriteData;
      running_d = (WriteData != 32'd0);
      tdone_evt = (WriteData == 32'd0);
    end else if (running_q) begin
      if (count_q <= 32'd1) begin
        count_d   = 32'd0;
        running_d = 1'b0;
        tdone_evt = 1'b1;
      end else begin
        count_d = count_q - 32'd1;
      end
    end

    // Set events dominate a simultaneous write-one-to-clear.
    rise_d  = rise_evt  | (rise_q  & ~(wr_status & WriteData[0]));
    tdone_d = tdone_evt | (tdone_q & ~(wr_status & WriteData[1]));
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= 32'd0;
      sync1_q    <= 8'd0;
      sync2_q    <= 8'd0;
      prev_q     <= 8'd0;
      rise_q     <= 1'b0;
      tdone_q    <= 1'b0;
      load_q     <= 32'd0;
      count_q    <= 32'd0;
      running_q  <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      sync1_q    <= PortIn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rise_q     <= rise_d;
      tdone_q    <= tdone_d;
      load_q     <= load_d;
      count_q    <= count_d;
      running_q  <= running_d;
    end
  end

  assign PortOut = port_out_q;
  assign Irq     = rise_q | tdone_q;

endmodule

`default_nettype wire
